// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures the half-period of a slow asynchronous square wave in clk cycles.
// Each interval between two consecutive synchronized edges is captured into a
// single-entry valid/ready output register. The interval before the first edge
// and any interval that ran into the stall timeout are discarded.
module clock_period_meter #(
  parameter int                CNT_W   = 26,
  parameter logic [CNT_W-1:0]  TIMEOUT = 26'd50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_half,
  output logic             meas_level,
  output logic             stalled,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Synchronizer, previous-value register, FSM and counter state
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled_q, stalled_d;

  // Output register
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             level_q, level_d;
  logic             overrun_q, overrun_d;

  logic             edge_s;
  logic             capture_s;

  assign edge_s = s2_q ^ s3_q;

  // Input synchronizer chain: s1/s2 resolve metastability, s3 holds the previous level
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Interval FSM: counts cycles between edges and decides when an interval is a valid capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stalled_d = stalled_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The interval before the first edge is partial, so only start counting.
        if (edge_s) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MEASURE: begin
        // An edge landing exactly at cnt == TIMEOUT still captures TIMEOUT.
        if (edge_s) begin
          capture_s = 1'b1;
          cnt_d     = CNT_ONE;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = ST_STALL;
          stalled_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STALL: begin
        // The interval that timed out is too long to report; resume on the next edge.
        if (edge_s) begin
          state_d   = ST_MEASURE;
          cnt_d     = CNT_ONE;
          stalled_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        stalled_d = 1'b0;
      end
    endcase
  end

  // Result register: a new capture always wins; losing an unread result sets the sticky overrun
  always_comb begin
    valid_d   = valid_q;
    half_d    = half_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (capture_s) begin
      half_d  = cnt_q;
      level_d = s3_q;
      valid_d = 1'b1;
      if (valid_q && !meas_ready) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stalled_q <= 1'b0;
      valid_q   <= 1'b0;
      half_q    <= '0;
      level_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stalled_q <= stalled_d;
      valid_q   <= valid_d;
      half_q    <= half_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  assign meas_valid = valid_q;
  assign meas_half  = half_q;
  assign meas_level = level_q;
  assign stalled    = stalled_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with TIMEOUT = 1000.
// Inputs change 1 ns after a rising clk edge; outputs are sampled at the same point.
// A sig_in change made there is seen by the DUT three rising edges later.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int               CNT_W = 26;
  localparam logic [CNT_W-1:0] TO    = 26'd1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_half;
  logic             meas_level;
  logic             stalled;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .meas_half  (meas_half),
    .meas_level (meas_level),
    .stalled    (stalled),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // wait n rising edges (n >= 1), then step 1 ns past the edge
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // toggle sig_in and wait until its capture (if any) is visible
  task automatic toggle3();
    sig_in = ~sig_in;
    cycles(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; sig_in = 1'b0; meas_ready = 1'b0;
    cycles(3);
    total++;
    if ({meas_valid, meas_half, meas_level, stalled, overrun} !== {1'b0, 26'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got v=%0b h=%0d l=%0b st=%0b ov=%0b, want all 0",
               meas_valid, meas_half, meas_level, stalled, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_toggle_10();
    logic exp_l;
    meas_ready = 1'b1;
    toggle3();
    total++;
    if (meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_edge_discard: got valid=%0b, want 0", meas_valid);
    end
    for (int k = 0; k < 3; k++) begin
      cycles(7);
      toggle3();
      exp_l = ~sig_in;
      total++;
      if ({meas_valid, meas_half, meas_level, stalled, overrun} !== {1'b1, 26'd10, exp_l, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL toggle10_%0d: got v=%0b h=%0d l=%0b st=%0b ov=%0b, want v=1 h=10 l=%0b st=0 ov=0",
                 k, meas_valid, meas_half, meas_level, stalled, overrun, exp_l);
      end
    end
  endtask

  task automatic test_asym();
    cycles(7);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd10, 1'b0}) begin
      bad++;
      $display("FAIL asym_lead: got v=%0b h=%0d l=%0b, want v=1 h=10 l=0", meas_valid, meas_half, meas_level);
    end
    for (int k = 0; k < 2; k++) begin
      cycles(4);
      toggle3();
      total++;
      if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd7, 1'b1}) begin
        bad++;
        $display("FAIL asym_high_%0d: got v=%0b h=%0d l=%0b, want v=1 h=7 l=1", k, meas_valid, meas_half, meas_level);
      end
      cycles(10);
      toggle3();
      total++;
      if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd13, 1'b0}) begin
        bad++;
        $display("FAIL asym_low_%0d: got v=%0b h=%0d l=%0b, want v=1 h=13 l=0", k, meas_valid, meas_half, meas_level);
      end
    end
  endtask

  task automatic test_overrun();
    cycles(7);
    meas_ready = 1'b0;
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd10, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ovr_first: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=10 l=1 ov=0",
               meas_valid, meas_half, meas_level, overrun);
    end
    cycles(7);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd10, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ovr_second: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=10 l=0 ov=1",
               meas_valid, meas_half, meas_level, overrun);
    end
    cycles(3);
    total++;
    if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd10, 1'b0}) begin
      bad++;
      $display("FAIL ovr_hold_stable: got v=%0b h=%0d l=%0b, want v=1 h=10 l=0", meas_valid, meas_half, meas_level);
    end
    cycles(4);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd10, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ovr_third: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=10 l=1 ov=1",
               meas_valid, meas_half, meas_level, overrun);
    end
    meas_ready = 1'b1;
    cycles(1);
    meas_ready = 1'b0;
    total++;
    if ({meas_valid, overrun} !== {1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ovr_drain: got v=%0b ov=%0b, want v=0 ov=1", meas_valid, overrun);
    end
  endtask

  task automatic test_stall();
    meas_ready = 1'b1;
    cycles(6);
    toggle3();
    total++;
    if ({meas_valid, meas_half, stalled} !== {1'b1, 26'd10, 1'b0}) begin
      bad++;
      $display("FAIL stall_pre_capture: got v=%0b h=%0d st=%0b, want v=1 h=10 st=0", meas_valid, meas_half, stalled);
    end
    cycles(int'(TO) - 1);
    total++;
    if (stalled !== 1'b0) begin
      bad++;
      $display("FAIL stall_early: got stalled=%0b, want 0", stalled);
    end
    cycles(1);
    total++;
    if ({stalled, meas_valid} !== {1'b1, 1'b0}) begin
      bad++;
      $display("FAIL stall_assert: got st=%0b v=%0b, want st=1 v=0", stalled, meas_valid);
    end
    toggle3();
    total++;
    if ({meas_valid, stalled} !== {1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stall_exit: got v=%0b st=%0b, want v=0 st=0", meas_valid, stalled);
    end
    cycles(17);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, stalled} !== {1'b1, 26'd20, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stall_resume: got v=%0b h=%0d l=%0b st=%0b, want v=1 h=20 l=0 st=0",
               meas_valid, meas_half, meas_level, stalled);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; sig_in = 1'b0; meas_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    toggle3();
    cycles(7);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd10, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_pre: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=10 l=1 ov=0",
               meas_valid, meas_half, meas_level, overrun);
    end
    cycles(9);
    sig_in = ~sig_in;
    cycles(2);
    meas_ready = 1'b1;
    cycles(1);
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd12, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_same_cycle: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=12 l=0 ov=0",
               meas_valid, meas_half, meas_level, overrun);
    end
    cycles(1);
    total++;
    if (meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_consume: got valid=%0b, want 0", meas_valid);
    end
  endtask

  task automatic test_reset_mid();
    meas_ready = 1'b0;
    cycles(6);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd10, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_pre: got v=%0b h=%0d l=%0b, want v=1 h=10 l=1", meas_valid, meas_half, meas_level);
    end
    cycles(2);
    rst = 1'b1;
    #1;
    total++;
    if ({meas_valid, meas_half, meas_level, stalled, overrun} !== {1'b0, 26'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_async: got v=%0b h=%0d l=%0b st=%0b ov=%0b, want all 0",
               meas_valid, meas_half, meas_level, stalled, overrun);
    end
    cycles(2);
    rst = 1'b0;
    meas_ready = 1'b1;
    toggle3();
    total++;
    if (meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_discard: got valid=%0b, want 0", meas_valid);
    end
    cycles(7);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level} !== {1'b1, 26'd10, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_second: got v=%0b h=%0d l=%0b, want v=1 h=10 l=1", meas_valid, meas_half, meas_level);
    end
  endtask

  task automatic test_min_period();
    cycles(7);
    for (int k = 0; k < 6; k++) begin
      sig_in = ~sig_in;
      cycles(1);
    end
    total++;
    if ({meas_valid, meas_half, meas_level, overrun} !== {1'b1, 26'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL min_period: got v=%0b h=%0d l=%0b ov=%0b, want v=1 h=1 l=1 ov=0",
               meas_valid, meas_half, meas_level, overrun);
    end
  endtask

  task automatic test_timeout_boundary();
    cycles(10);
    toggle3();
    cycles(int'(TO) - 3);
    toggle3();
    total++;
    if ({meas_valid, meas_half, meas_level, stalled} !== {1'b1, TO, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL timeout_boundary: got v=%0b h=%0d l=%0b st=%0b, want v=1 h=%0d l=1 st=0",
               meas_valid, meas_half, meas_level, stalled, TO);
    end
  endtask

  initial begin
    test_reset();
    test_toggle_10();
    test_asym();
    test_overrun();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_min_period();
    test_timeout_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the half-period of a slow, asynchronous square-wave input in system-clock cycles and presents each measurement on a valid/ready output. It runs on the 100 MHz system clock. It is the receive-side counterpart of our clock divider: fed a divided clock, it recovers the toggle interval, which is the divider constant + 1. It is used for bring-up checks of generated clocks and for measuring external slow signals (encoders, sensor pulses).

## Interface
- CNT_W, 26: width of the half-period counter and result.
- TIMEOUT, 26'd50000000: cycles without an edge before the stall flag is raised (0.5 s at 100 MHz). Must satisfy 2 ≤ TIMEOUT < 2^CNT_W − 1.
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal under measurement.
- meas_ready  input  1  consumer accepts the result when meas_valid && meas_ready.
- meas_valid  output  1  meas_half/meas_level hold an unconsumed result.
- meas_half  output  CNT_W  clk cycles between two consecutive detected edges.
- meas_level  output  1  sig_in level during the measured interval.
- stalled  output  1  no edge for TIMEOUT cycles; cleared by the next edge.
- overrun  output  1  sticky: a result was overwritten before it was accepted.

## Operation
- Input path: 2-flop synchronizer (s1, s2), then a previous-value register s3. edge = s2 ^ s3. level_prev = s3.
- Counter cnt (CNT_W):
  - On edge, cnt <= 1.
  - Otherwise, in MEASURE, cnt <= cnt + 1. It never exceeds TIMEOUT.
- FSM states: IDLE, MEASURE, STALL.
- IDLE (reset state):
  - Waits for the first edge.
  - On edge, go to MEASURE and set cnt <= 1.
  - No capture, because the interval before the first edge is partial.
- MEASURE:
  - On edge, capture meas_half <= cnt and meas_level <= level_prev; restart cnt at 1.
  - If there is no edge and cnt == TIMEOUT, go to STALL and set stalled <= 1. cnt holds.
- STALL:
  - On edge, go to MEASURE, set cnt <= 1 and stalled <= 0.
  - No capture, because the interval was too long to be valid.
- Output register:
  - On capture, meas_half and meas_level load.
  - If meas_valid && !meas_ready in the same cycle, also set overrun <= 1 (the old data is lost and the new data wins).
  - meas_valid <= 1 on capture. Otherwise it clears on meas_valid && meas_ready.
  - Capture and handshake in the same cycle: the new value loads, meas_valid stays 1, and overrun is not set.
- overrun is cleared only by rst.
- meas_half and meas_level are stable while meas_valid && !meas_ready, unless a new capture overwrites them.
- Width rule: meas_half is unsigned. The maximum value is TIMEOUT; an edge arriving exactly when cnt == TIMEOUT is still a valid capture of TIMEOUT.

## Timing
- Reset values:
  - s1, s2, s3, cnt all 0; state IDLE.
  - meas_valid, meas_half, meas_level, stalled, overrun all 0.
- Latency: a sig_in change sampled at clk edge E0 gives edge = 1 in the cycle after E1. Capture happens at E2, so meas_valid is high from E2 (3 rising edges).
- Resolution: ±1 cycle from synchronizer sampling. Pulses shorter than one clk period may be missed.
- A 100 MHz-domain toggle every N cycles reads exactly N. Clock divider constant D therefore reads D+1 (200001).
- Minimum measurable half-period: 1 cycle (sig_in toggling at clk/2 reads 1). No internal buffering beyond one result.
- Reset mid-measurement: all state returns to reset values immediately (asynchronous). The first edge after deassertion is discarded, as in IDLE.
- stalled asserts in the cycle after cnt reaches TIMEOUT, i.e. TIMEOUT+1 cycles after the last edge was registered.

## Test plan
Use TIMEOUT=1000 in simulation.
1. After reset, sig_in toggles every 10 cycles, meas_ready=1 → no result for the first edge; every later edge gives meas_half=10 with meas_level alternating; overrun=0, stalled=0.
2. sig_in high 7 / low 13 cycles → results 7 with meas_level=1 and 13 with meas_level=0, alternating.
3. meas_ready=0 across three edges with 10-cycle spacing → meas_valid=1, meas_half=10 (latest), overrun=1. Then meas_ready=1 for one cycle → meas_valid=0, and overrun stays 1.
4. sig_in held constant after an edge → stalled=1 exactly TIMEOUT+1 cycles after the edge was registered. The next edge gives no meas_valid and stalled=0. The following edge, 20 cycles later, gives meas_half=20.
5. Capture and handshake in the same cycle (meas_valid=1, meas_ready=1, edge) → new meas_half loaded, meas_valid stays 1, overrun=0.
6. rst pulsed mid-interval with meas_valid=1 → all outputs 0 immediately. The first post-reset edge is discarded; the second gives a correct value.
